channel_model: RTL and testbench
================================

Name: channel_model

Overview:
- Parametrised noisy-channel model for the transmit/receive link bench path; successor to the fixed 9-bit Johnson-noise channel.
- Adds selectable noise sources (clean, Johnson, LFSR, LFSR plus burst erasure), noise attenuation, and a reloadable LFSR seed.
- Adds configurable pipeline latency and a valid signal aligned with the data.
- Sits between the modulator/encoder output and the receiver/decoder input.

Parameters:
- DATA_W, 9: signed sample width of in_data and out_data.
- NOISE_W, 5: noise word width; also the Johnson counter length.
- DELAY, 2: latency in cycles from in to out; must be >= 1.
- LFSR_W, 16: width of the Galois LFSR.
- LFSR_TAPS, 16'hB400: Galois feedback mask.
- LFSR_SEED, 16'hACE1: LFSR value at reset, and the substitute for a zero seed.
- BURST_LEN, 8: erasure burst length in cycles; must be >= 1.

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: in_data carries a symbol this cycle. When low, the channel outputs noise only.
- in_data, input, DATA_W: signed transmitted sample.
- mode, input, 2: noise source select. 0 clean, 1 Johnson, 2 LFSR, 3 LFSR plus burst erasure.
- attn, input, 3: arithmetic right shift applied to noise. Values >= NOISE_W give an all-sign-bit result.
- seed_load, input, 1: synchronous load of the LFSR.
- seed, input, LFSR_W: LFSR load value.
- out_valid, output, 1: in_valid delayed by DELAY cycles.
- out_data, output, DATA_W: signed received sample.
- sat_flag, output, 1: saturation occurred on this out_data. Aligned with out_data.
- burst_active, output, 1: burst FSM is in BURST. Not delayed.

Behaviour:
- Reset (reset low, asynchronous):
  - Johnson counter = 0; LFSR = LFSR_SEED; FSM = IDLE; burst count = 0.
  - All pipeline stages clear: out_data = 0, out_valid = 0, sat_flag = 0, burst_active = 0.
- Reset asserted mid-burst or mid-pipeline discards all in-flight samples.
- Johnson counter:
  - Advances every cycle regardless of mode: shift left, LSB <= ~MSB.
  - Period is 2*NOISE_W.
  - Value is interpreted as signed NOISE_W.
- LFSR:
  - Advances every cycle: if lsb == 1, next = (lfsr >> 1) ^ LFSR_TAPS; otherwise next = lfsr >> 1.
  - Noise is the low NOISE_W bits of the current (pre-advance) state, interpreted as signed.
  - seed_load has priority over advance: LFSR <= seed, or LFSR_SEED if seed == 0, so the LFSR cannot lock up.
- Noise term n:
  - Mode 0: n = 0.
  - Mode 1: n = Johnson value.
  - Modes 2 and 3: n = LFSR low bits.
  - Then n = n >>> attn, and n is sign-extended to DATA_W+1 bits.
- Data term d:
  - d = sign-extended in_data when in_valid = 1 and the FSM is not in BURST.
  - Otherwise d = 0.
- Sum: s = d + n, computed at DATA_W+1 bits.
- Burst FSM, states IDLE and BURST:
  - IDLE -> BURST when mode == 3 and the top 4 LFSR bits == 0. Erasure starts the next cycle.
  - BURST lasts exactly BURST_LEN cycles, then returns to IDLE.
  - BURST -> IDLE immediately if mode != 3, which aborts the burst.
  - A seed_load during BURST does not affect the burst count.
- Pipeline:
  - Stage 1 registers {in_valid, s, sat}.
  - DELAY-1 further register stages follow.
  - Total latency is exactly DELAY cycles, and a new sample is accepted every cycle.
- Mode and attn changes take effect on the sample in the same cycle; there is no pipeline flush.

Optional Feature:
- CHANNEL_SAT_EN defined:
  - If s exceeds the signed DATA_W range, out_data clamps to 2^(DATA_W-1)-1 or -2^(DATA_W-1).
  - sat_flag = 1 for that sample.
- CHANNEL_SAT_EN undefined:
  - out_data = s[DATA_W-1:0], i.e. two's-complement wrap.
  - sat_flag is tied to 0.

Decomposition:
- Shared package channel_pkg holds:
  - mode encodings MODE_CLEAN, MODE_JOHNSON, MODE_LFSR, MODE_BURST;
  - burst FSM state typedef;
  - the default LFSR_TAPS and LFSR_SEED constants.
- One sub-module, channel_noise_gen, contains the Johnson counter, the LFSR and the seed load.
- It outputs johnson_n, lfsr_n and lfsr_top; the top-level module keeps the FSM, sum, saturation and pipeline.

Test Plan (defaults unless stated):
- Clean path: mode 0, DELAY=2, in_valid=1, in_data=100 at cycle t -> out_data=100, out_valid=1 at t+2, and out_valid=0 at t+1.
- Johnson noise: mode 1, attn=0, in_valid=0 from reset -> out_data sequence 0,1,3,7,15,-1,-2,-4,-8,-16, then repeats.
- LFSR noise: mode 2, attn=0, in_valid=0 from reset -> first two noise samples are 1 (state 0xACE1) then -16 (state 0xE270).
  - attn=2 on the second sample gives -4.
- Saturation: mode 1, in_data=255 when Johnson value = 15:
  - with CHANNEL_SAT_EN: out_data=255, sat_flag=1;
  - without CHANNEL_SAT_EN: out_data=-242, sat_flag=0.
- Burst: mode 3, seed_load with seed whose top nibble is 0 and in_data=50 held ->
  - burst_active high for 8 cycles;
  - out_data = noise only for those 8 cycles;
  - mode switched to 2 mid-burst drops burst_active on the next cycle.
- Seed and reset:
  - seed_load with seed=0 -> LFSR = 0xACE1.
  - reset pulsed low mid-stream -> out_data=0, out_valid=0, burst_active=0 immediately; the Johnson sequence restarts at 0.

Source files
------------

// File: rtl/channel_pkg.sv
// Shared definitions for the noisy-channel model: noise-source encodings,
// burst FSM states and the default Galois LFSR constants.
package channel_pkg;

  typedef enum logic [1:0] {
    MODE_CLEAN   = 2'd0,
    MODE_JOHNSON = 2'd1,
    MODE_LFSR    = 2'd2,
    MODE_BURST   = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_e;

  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/channel_if.sv
// Sample/control bundle between the link bench driver and the channel model.
interface channel_if #(
  parameter int DATA_W = 9,
  parameter int LFSR_W = 16
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic [1:0]               mode;
  logic [2:0]               attn;
  logic                     seed_load;
  logic [LFSR_W-1:0]        seed;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     sat_flag;
  logic                     burst_active;

  modport master (
    output in_valid, in_data, mode, attn, seed_load, seed,
    input  out_valid, out_data, sat_flag, burst_active
  );

  modport slave (
    input  in_valid, in_data, mode, attn, seed_load, seed,
    output out_valid, out_data, sat_flag, burst_active
  );
endinterface

// File: rtl/channel_noise_gen.sv
// Free-running noise sources: Johnson counter and Galois LFSR with a
// reloadable seed (a zero seed is replaced by LFSR_SEED to avoid lock-up).
module channel_noise_gen
  import channel_pkg::*;
#(
  parameter int                NOISE_W   = 5,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      seed_load,
  input  logic [LFSR_W-1:0]         seed,
  output logic signed [NOISE_W-1:0] johnson_n,
  output logic signed [NOISE_W-1:0] lfsr_n,
  output logic [3:0]                lfsr_top
);

  logic [NOISE_W-1:0] johnson;
  logic [LFSR_W-1:0]  lfsr;
  logic [LFSR_W-1:0]  lfsr_next;

  // NOTE: every branch assigns lfsr_next, so no latch can be inferred here.
  always_comb begin
    if (seed_load) begin
      lfsr_next = (seed == '0) ? LFSR_SEED : seed;
    end else if (lfsr[0]) begin
      lfsr_next = (lfsr >> 1) ^ LFSR_TAPS;
    end else begin
      lfsr_next = lfsr >> 1;
    end
  end

  // NOTE: non-blocking assignments keep both registers updating from the
  // same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      johnson <= '0;
      lfsr    <= LFSR_SEED;
    end else begin
      johnson <= {johnson[NOISE_W-2:0], ~johnson[NOISE_W-1]};
      lfsr    <= lfsr_next;
    end
  end

  assign johnson_n = $signed(johnson);
  assign lfsr_n    = $signed(lfsr[NOISE_W-1:0]);
  assign lfsr_top  = lfsr[LFSR_W-1 -: 4];

endmodule

// File: rtl/channel_model.sv
// Noisy channel: selectable noise, attenuation, burst erasure and a DELAY-deep
// output pipeline. Define CHANNEL_SAT_EN to clamp instead of wrapping the sum.
module channel_model
  import channel_pkg::*;
#(
  parameter int                DATA_W    = 9,
  parameter int                NOISE_W   = 5,
  parameter int                DELAY     = 2,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
  parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED,
  parameter int                BURST_LEN = 8
) (
  input  logic     clk,
  input  logic     reset,
  channel_if.slave io
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef struct packed {
    logic              valid;
    logic              sat;
    logic [DATA_W-1:0] data;
  } stage_t;

  logic signed [NOISE_W-1:0] johnson_n, lfsr_n, noise, noise_sh;
  logic [3:0]                lfsr_top;
  logic [DATA_W:0]           noise_ext, data_ext, sum;
  logic [DATA_W-1:0]         clipped;
  logic                      sat;
  mode_e                     mode;
  burst_state_e              state, next_state;
  logic [CNT_W-1:0]          burst_cnt, next_cnt;
  stage_t                    pipe [DELAY];

  channel_noise_gen #(
    .NOISE_W  (NOISE_W),
    .LFSR_W   (LFSR_W),
    .LFSR_TAPS(LFSR_TAPS),
    .LFSR_SEED(LFSR_SEED)
  ) u_noise (
    .clk      (clk),
    .reset    (reset),
    .seed_load(io.seed_load),
    .seed     (io.seed),
    .johnson_n(johnson_n),
    .lfsr_n   (lfsr_n),
    .lfsr_top (lfsr_top)
  );

  assign mode = mode_e'(io.mode);

  always_comb begin
    noise = '0;
    case (mode)
      MODE_JOHNSON:          noise = johnson_n;
      MODE_LFSR, MODE_BURST: noise = lfsr_n;
      default:               noise = '0;
    endcase
  end

  assign noise_sh  = noise >>> io.attn;
  assign noise_ext = {{(DATA_W+1-NOISE_W){noise_sh[NOISE_W-1]}}, noise_sh};
  assign data_ext  = (io.in_valid && state != BURST) ?
                     {io.in_data[DATA_W-1], io.in_data} : '0;
  assign sum       = data_ext + noise_ext;

`ifdef CHANNEL_SAT_EN
  always_comb begin
    sat = (sum[DATA_W] != sum[DATA_W-1]);
    if (!sat)             clipped = sum[DATA_W-1:0];
    else if (sum[DATA_W]) clipped = {1'b1, {(DATA_W-1){1'b0}}};
    else                  clipped = {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  logic unused_sum_msb;
  assign unused_sum_msb = sum[DATA_W];
  assign sat            = 1'b0;
  assign clipped        = sum[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= next_state;
      burst_cnt <= next_cnt;
    end
  end

  // Leaving mode 3 aborts a burst at once; otherwise it runs BURST_LEN cycles.
  always_comb begin
    next_state = state;
    next_cnt   = burst_cnt;
    case (state)
      IDLE: begin
        if (mode == MODE_BURST && lfsr_top == 4'h0) begin
          next_state = BURST;
          next_cnt   = '0;
        end
      end
      BURST: begin
        if (mode != MODE_BURST || burst_cnt == CNT_W'(BURST_LEN - 1)) begin
          next_state = IDLE;
          next_cnt   = '0;
        end else begin
          next_cnt = burst_cnt + 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign io.burst_active = (state == BURST);

  // NOTE: pipeline stages are reset so a reset discards in-flight samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: io.in_valid, sat: sat, data: clipped};
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign io.out_valid = pipe[DELAY-1].valid;
  assign io.out_data  = pipe[DELAY-1].data;
  assign io.sat_flag  = pipe[DELAY-1].sat;

endmodule

// File: tb/tb_channel_model.sv
// Self-checking bench for channel_model: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the channel.
module tb_channel_model;

  localparam int DATA_W    = 9;
  localparam int DELAY     = 2;
  localparam int BURST_LEN = 8;

  typedef struct {
    bit v;
    int d;
    bit sat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  int        m_jidx;
  bit [15:0] m_lfsr;
  int        m_rem;
  exp_t      m_q[$];

  channel_if #(.DATA_W(DATA_W), .LFSR_W(16)) bus ();

  channel_model #(
    .DATA_W   (DATA_W),
    .NOISE_W  (5),
    .DELAY    (DELAY),
    .LFSR_W   (16),
    .LFSR_TAPS(16'hB400),
    .LFSR_SEED(16'hACE1),
    .BURST_LEN(BURST_LEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time=%0t required end before", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int jval(input int k);
    return (k < 5) ? (1 << k) - 1 : -(1 << (k - 5));
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{v: 1'b0, d: 0, sat: 1'b0};
    m_jidx = 0;
    m_lfsr = 16'hACE1;
    m_rem  = 0;
    m_q.delete();
    for (int i = 0; i < DELAY - 1; i++) m_q.push_back(z);
  endtask

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mode      = 2'd0;
    bus.attn      = 3'd0;
    bus.seed_load = 1'b0;
    bus.seed      = '0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus; returns the model's expectation for the outputs
  // visible just after the edge.
  task automatic cycle(input bit iv, input int id, input bit [1:0] md,
                       input bit [2:0] at, input bit sl, input bit [15:0] sd,
                       output exp_t e, output bit eb);
    int   n, d, s;
    bit   in_burst;
    exp_t x;
    bus.in_valid  = iv;
    bus.in_data   = DATA_W'(id);
    bus.mode      = md;
    bus.attn      = at;
    bus.seed_load = sl;
    bus.seed      = sd;
    in_burst = (m_rem > 0);
    case (md)
      2'd0:    n = 0;
      2'd1:    n = jval(m_jidx);
      default: begin
        n = int'(m_lfsr[4:0]);
        if (n >= 16) n = n - 32;
      end
    endcase
    n = n >>> at;
    d = (iv && !in_burst) ? id : 0;
    s = d + n;
    x.v = iv;
`ifdef CHANNEL_SAT_EN
    if (s > 255)       begin x.d = 255;  x.sat = 1'b1; end
    else if (s < -256) begin x.d = -256; x.sat = 1'b1; end
    else               begin x.d = s;    x.sat = 1'b0; end
`else
    x.d   = (((s + 256) % 512) + 512) % 512 - 256;
    x.sat = 1'b0;
`endif
    m_q.push_back(x);
    if (m_rem > 0)                          m_rem = (md != 2'd3) ? 0 : m_rem - 1;
    else if (md == 2'd3 && m_lfsr[15:12] == 4'h0) m_rem = BURST_LEN;
    m_jidx = (m_jidx + 1) % 10;
    if (sl)             m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
    else if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ 16'hB400;
    else                m_lfsr = m_lfsr >> 1;
    @(posedge clk);
    #1;
    e  = m_q.pop_front();
    eb = (m_rem > 0);
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid);
    end
    n_vec++;
    if (bus.out_data !== '0) begin
      n_err++; $display("FAIL reset out_data: got %0d want 0", bus.out_data);
    end
    n_vec++;
    if (bus.sat_flag !== 1'b0) begin
      n_err++; $display("FAIL reset sat_flag: got %b want 0", bus.sat_flag);
    end
    n_vec++;
    if (bus.burst_active !== 1'b0) begin
      n_err++; $display("FAIL reset burst_active: got %b want 0", bus.burst_active);
    end
  endtask

  task automatic test_clean();
    exp_t e; bit eb;
    apply_reset();
    cycle(1'b1, 100, 2'd0, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL clean t+1 out_valid: got %b want 0", bus.out_valid);
    end
    cycle(1'b0, 0, 2'd0, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 9'sd100) begin
      n_err++;
      $display("FAIL clean t+2: got valid=%b data=%0d want valid=1 data=100",
               bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_johnson();
    exp_t e; bit eb;
    int   jtab [10] = '{0, 1, 3, 7, 15, -1, -2, -4, -8, -16};
    apply_reset();
    for (int k = 0; k < 22; k++) begin
      cycle(1'b0, 0, 2'd1, 3'd0, 1'b0, 16'h0, e, eb);
      if (k >= 1) begin
        n_vec++;
        if (bus.out_data !== DATA_W'(jtab[(k-1) % 10]) || bus.out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL johnson sample %0d: got data=%0d valid=%b want data=%0d valid=0",
                   k - 1, bus.out_data, bus.out_valid, jtab[(k-1) % 10]);
        end
      end
    end
  endtask

  task automatic test_lfsr();
    exp_t e; bit eb;
    apply_reset();
    cycle(1'b0, 0, 2'd2, 3'd0, 1'b0, 16'h0, e, eb);
    cycle(1'b0, 0, 2'd2, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.out_data !== 9'sd1) begin
      n_err++; $display("FAIL lfsr sample0: got %0d want 1", bus.out_data);
    end
    cycle(1'b0, 0, 2'd2, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.out_data !== -9'sd16) begin
      n_err++; $display("FAIL lfsr sample1: got %0d want -16", bus.out_data);
    end
    apply_reset();
    cycle(1'b0, 0, 2'd2, 3'd0, 1'b0, 16'h0, e, eb);
    cycle(1'b0, 0, 2'd2, 3'd2, 1'b0, 16'h0, e, eb);
    cycle(1'b0, 0, 2'd2, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.out_data !== -9'sd4) begin
      n_err++; $display("FAIL lfsr attn2: got %0d want -4", bus.out_data);
    end
  endtask

  task automatic test_sat();
    exp_t e; bit eb;
    apply_reset();
    for (int k = 0; k < 4; k++) cycle(1'b0, 0, 2'd1, 3'd0, 1'b0, 16'h0, e, eb);
    cycle(1'b1, 255, 2'd1, 3'd0, 1'b0, 16'h0, e, eb);
    cycle(1'b0, 0, 2'd1, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
`ifdef CHANNEL_SAT_EN
    if (bus.out_data !== 9'sd255 || bus.sat_flag !== 1'b1) begin
      n_err++; $display("FAIL sat: got data=%0d sat=%b want data=255 sat=1",
                        bus.out_data, bus.sat_flag);
    end
`else
    if (bus.out_data !== -9'sd242 || bus.sat_flag !== 1'b0) begin
      n_err++; $display("FAIL wrap: got data=%0d sat=%b want data=-242 sat=0",
                        bus.out_data, bus.sat_flag);
    end
`endif
  endtask

  task automatic test_burst();
    exp_t e; bit eb;
    int   run = 0;
    bit   seen = 1'b0, done = 1'b0;
    apply_reset();
    cycle(1'b1, 50, 2'd3, 3'd0, 1'b1, 16'h0123, e, eb);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b1, 50, 2'd3, 3'd0, 1'b0, 16'h0, e, eb);
      n_vec++;
      if (bus.out_data !== DATA_W'(e.d) || bus.out_valid !== e.v ||
          bus.burst_active !== eb) begin
        n_err++;
        $display("FAIL burst cyc %0d: got data=%0d valid=%b burst=%b want data=%0d valid=%b burst=%b",
                 k, bus.out_data, bus.out_valid, bus.burst_active, e.d, e.v, eb);
      end
      if (bus.burst_active === 1'b1 && !done) begin seen = 1'b1; run++; end
      else if (seen) done = 1'b1;
    end
    n_vec++;
    if (run != BURST_LEN) begin
      n_err++; $display("FAIL burst length: got %0d cycles want %0d", run, BURST_LEN);
    end
    // Abort by leaving mode 3 mid-burst
    apply_reset();
    cycle(1'b1, 50, 2'd3, 3'd0, 1'b1, 16'h0123, e, eb);
    cycle(1'b1, 50, 2'd3, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.burst_active !== 1'b1) begin
      n_err++; $display("FAIL burst entry: got %b want 1", bus.burst_active);
    end
    cycle(1'b1, 50, 2'd3, 3'd0, 1'b0, 16'h0, e, eb);
    cycle(1'b1, 50, 2'd3, 3'd0, 1'b0, 16'h0, e, eb);
    cycle(1'b1, 50, 2'd2, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.burst_active !== 1'b0) begin
      n_err++; $display("FAIL burst abort: got %b want 0", bus.burst_active);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 50, 2'd2, 3'd0, 1'b0, 16'h0, e, eb);
      n_vec++;
      if (bus.out_data !== DATA_W'(e.d) || bus.burst_active !== eb) begin
        n_err++; $display("FAIL burst after abort %0d: got data=%0d burst=%b want data=%0d burst=%b",
                          k, bus.out_data, bus.burst_active, e.d, eb);
      end
    end
  endtask

  task automatic test_seed();
    exp_t e; bit eb;
    apply_reset();
    for (int k = 0; k < 5; k++) cycle(1'b0, 0, 2'd2, 3'd0, 1'b0, 16'h0, e, eb);
    cycle(1'b0, 0, 2'd2, 3'd0, 1'b1, 16'h0, e, eb);
    cycle(1'b0, 0, 2'd2, 3'd0, 1'b0, 16'h0, e, eb);
    cycle(1'b0, 0, 2'd2, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.out_data !== 9'sd1) begin
      n_err++; $display("FAIL zero seed: got noise %0d want 1 (state 0xACE1)", bus.out_data);
    end
  endtask

  task automatic test_random();
    exp_t      e; bit eb;
    bit [1:0]  md = 2'd0;
    bit [2:0]  at = 3'd0;
    bit        iv, sl;
    bit [15:0] sd;
    int        id;
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0)  at = 3'($urandom_range(0, 7));
      iv = 1'($urandom_range(0, 1));
      id = int'($urandom_range(0, 511)) - 256;
      sl = ($urandom_range(0, 31) == 0);
      case ($urandom_range(0, 2))
        0:       sd = 16'h0;
        1:       sd = 16'($urandom_range(0, 16'h0FFF));
        default: sd = 16'($urandom_range(0, 16'hFFFF));
      endcase
      cycle(iv, id, md, at, sl, sd, e, eb);
      n_vec++;
      if (bus.out_valid !== e.v || bus.out_data !== DATA_W'(e.d) ||
          bus.sat_flag !== e.sat || bus.burst_active !== eb) begin
        n_err++;
        $display("FAIL random cyc %0d: got v/d/s/b=%b/%0d/%b/%b want %b/%0d/%b/%b",
                 k, bus.out_valid, bus.out_data, bus.sat_flag, bus.burst_active,
                 e.v, e.d, e.sat, eb);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; bit eb;
    apply_reset();
    cycle(1'b1, 50, 2'd3, 3'd0, 1'b1, 16'h0123, e, eb);
    cycle(1'b1, 50, 2'd3, 3'd0, 1'b0, 16'h0, e, eb);
    cycle(1'b1, 50, 2'd3, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.burst_active !== 1'b1 || bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL pre-reset state: got burst=%b valid=%b want 1/1",
                        bus.burst_active, bus.out_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.out_data !== '0 || bus.out_valid !== 1'b0 || bus.burst_active !== 1'b0) begin
      n_err++; $display("FAIL async reset: got data=%0d valid=%b burst=%b want 0/0/0",
                        bus.out_data, bus.out_valid, bus.burst_active);
    end
    drive_idle();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    cycle(1'b0, 0, 2'd1, 3'd0, 1'b0, 16'h0, e, eb);
    cycle(1'b0, 0, 2'd1, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.out_data !== 9'sd0) begin
      n_err++; $display("FAIL johnson restart 0: got %0d want 0", bus.out_data);
    end
    cycle(1'b0, 0, 2'd1, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.out_data !== 9'sd1) begin
      n_err++; $display("FAIL johnson restart 1: got %0d want 1", bus.out_data);
    end
    cycle(1'b0, 0, 2'd1, 3'd0, 1'b0, 16'h0, e, eb);
    n_vec++;
    if (bus.out_data !== 9'sd3) begin
      n_err++; $display("FAIL johnson restart 2: got %0d want 3", bus.out_data);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    test_reset();
    test_clean();
    test_johnson();
    test_lfsr();
    test_sat();
    test_burst();
    test_seed();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
